// File: rtl/soml_load_sequencer.sv
// Load sequencer: receives a framed byte stream from the UART, writes the H and Y
// matrices into the decoder stores, starts the decoder, and returns its 12-bit
// result as two bytes to the UART transmitter.
module soml_load_sequencer #(
  parameter int N           = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         wr_en,
  output logic [1:0]   wr_sel,
  output logic [1:0]   wr_row,
  output logic [1:0]   wr_col,
  output logic         wr_imag,
  output logic [N-1:0] wr_data,
  output logic         start_calc,
  input  logic         calc_valid,
  input  logic [11:0]  calc_result,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         frame_err
);

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [5:0] FRAME_WORDS = 6'd48;
  localparam int         IW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_TX_HI,
    S_TX_LO
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [1:0]    r_byteCnt;
  logic [5:0]    r_wordCnt;
  logic [IW-1:0] r_idleCnt;
  logic [N-1:0]  r_shift;
  logic          r_wrEn;
  logic [1:0]    r_wrSel;
  logic [1:0]    r_wrRow;
  logic [1:0]    r_wrCol;
  logic          r_wrImag;
  logic [N-1:0]  r_wrData;
  logic          r_frameErr;
  logic [11:0]   r_result;

  logic          w_syncHit;
  logic          w_byteAccept;
  logic          w_wordDone;
  logic          w_frameDone;
  logic          w_timeout;
  logic [N-1:0]  w_word;
  logic [1:0]    w_sel;
  logic [1:0]    w_row;
  logic [1:0]    w_col;
  logic          w_imag;

  // Event decode: sync detection, byte acceptance, word completion, frame end, timeout.
  always_comb begin
    w_syncHit    = (r_state == S_IDLE) && rx_valid && (rx_data == SYNC_BYTE);
    w_byteAccept = (r_state == S_LOAD) && rx_valid && (r_wordCnt < FRAME_WORDS);
    w_wordDone   = w_byteAccept && (r_byteCnt == 2'd3);
    w_frameDone  = (r_state == S_LOAD) && r_wrEn && (r_wordCnt == FRAME_WORDS);
    w_timeout    = (r_state == S_LOAD) && !rx_valid && (r_idleCnt == IDLE_LIMIT);
    w_word       = {r_shift[N-9:0], rx_data};
  end

  // Word index to store address: words 0..31 fill H, words 32..47 fill the two Y columns.
  always_comb begin
    w_sel  = 2'd0;
    w_row  = 2'd0;
    w_col  = 2'd0;
    w_imag = r_wordCnt[0];
    if (!r_wordCnt[5]) begin
      w_row = r_wordCnt[4:3];
      w_col = r_wordCnt[2:1];
    end else begin
      w_sel = r_wordCnt[3] ? 2'd2 : 2'd1;
      w_row = r_wordCnt[2:1];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a completed frame takes priority over a coincident timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_syncHit) w_next = S_LOAD;
      S_LOAD: begin
        if (w_frameDone) begin
          w_next = S_START;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_START: w_next = S_WAIT;
      S_WAIT:  if (calc_valid) w_next = S_TX_HI;
      S_TX_HI: if (tx_ready) w_next = S_TX_LO;
      S_TX_LO: if (tx_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Byte and word counters, cleared by each accepted sync byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byteCnt <= 2'd0;
      r_wordCnt <= 6'd0;
    end else if (w_syncHit) begin
      r_byteCnt <= 2'd0;
      r_wordCnt <= 6'd0;
    end else if (w_byteAccept) begin
      r_byteCnt <= r_byteCnt + 2'd1;
      if (r_byteCnt == 2'd3) begin
        r_wordCnt <= r_wordCnt + 6'd1;
      end
    end
  end

  // Idle counter: only runs in LOAD and restarts on every received byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idleCnt <= '0;
    end else if ((r_state != S_LOAD) || rx_valid) begin
      r_idleCnt <= '0;
    end else if (!w_timeout) begin
      r_idleCnt <= r_idleCnt + 1'b1;
    end
  end

  // Byte shift register, MSB first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
    end else if (w_byteAccept) begin
      r_shift <= w_word;
    end
  end

  // Write port: one-cycle strobe after the fourth byte, with address and data held steady.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrEn   <= 1'b0;
      r_wrSel  <= 2'd0;
      r_wrRow  <= 2'd0;
      r_wrCol  <= 2'd0;
      r_wrImag <= 1'b0;
      r_wrData <= '0;
    end else begin
      r_wrEn <= w_wordDone;
      if (w_wordDone) begin
        r_wrSel  <= w_sel;
        r_wrRow  <= w_row;
        r_wrCol  <= w_col;
        r_wrImag <= w_imag;
        r_wrData <= w_word;
      end
    end
  end

  // Sticky frame error: set by a LOAD timeout, cleared by the next accepted sync byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frameErr <= 1'b0;
    end else if (w_timeout) begin
      r_frameErr <= 1'b1;
    end else if (w_syncHit) begin
      r_frameErr <= 1'b0;
    end
  end

  // Decoder result capture, only while waiting for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result <= 12'd0;
    end else if ((r_state == S_WAIT) && calc_valid) begin
      r_result <= calc_result;
    end
  end

  // Outputs decoded from state so they follow reset without waiting for a clock edge.
  always_comb begin
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    start_calc = (r_state == S_START);
    busy       = (r_state != S_IDLE);
    if (r_state == S_TX_HI) begin
      tx_valid = 1'b1;
      tx_data  = {4'h0, r_result[11:8]};
    end else if (r_state == S_TX_LO) begin
      tx_valid = 1'b1;
      tx_data  = r_result[7:0];
    end
  end

  assign wr_en     = r_wrEn;
  assign wr_sel    = r_wrSel;
  assign wr_row    = r_wrRow;
  assign wr_col    = r_wrCol;
  assign wr_imag   = r_wrImag;
  assign wr_data   = r_wrData;
  assign frame_err = r_frameErr;

endmodule

// File: tb/tb_soml_load_sequencer.sv
// Scoreboard bench for soml_load_sequencer: directed frames, result return,
// back-pressure, timeout, resync filtering and mid-frame reset.
module tb_soml_load_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [1:0]  wr_row;
  logic [1:0]  wr_col;
  logic        wr_imag;
  logic [31:0] wr_data;
  logic        start_calc;
  logic        calc_valid = 1'b0;
  logic [11:0] calc_result = 12'h000;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        frame_err;

  typedef struct packed {
    logic [1:0]  sel;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        imag;
    logic [31:0] data;
  } wr_t;

  wr_t        wrQ[$];
  logic [7:0] txQ[$];
  wr_t        expW;
  logic [7:0] expTx;
  int         startPending = 0;
  int         checks = 0;
  int         errors = 0;

  logic [31:0] yTab [16] = '{
    32'h0016_A09E, 32'h0000_0000, 32'hFFE9_5F62, 32'h0000_0000,
    32'h0000_0000, 32'h0016_A09E, 32'h0000_0000, 32'hFFE9_5F62,
    32'h0010_0000, 32'hFFF0_0000, 32'h0010_0000, 32'h0010_0000,
    32'hFFF0_0000, 32'h0010_0000, 32'hFFF0_0000, 32'hFFF0_0000
  };

  soml_load_sequencer #(.N(32), .TIMEOUT_CYC(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_imag     (wr_imag),
    .wr_data     (wr_data),
    .start_calc  (start_calc),
    .calc_valid  (calc_valid),
    .calc_result (calc_result),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Expected store address for word k, straight from the index formulas.
  function automatic wr_t expWr(input int k, input logic [31:0] d);
    wr_t e;
    int j;
    e.data = d;
    if (k < 32) begin
      e.sel  = 2'd0;
      e.row  = 2'(k / 8);
      e.col  = 2'((k / 2) % 4);
      e.imag = 1'(k % 2);
    end else begin
      j      = k - 32;
      e.sel  = 2'(1 + j / 8);
      e.row  = 2'((j / 2) % 4);
      e.col  = 2'd0;
      e.imag = 1'(j % 2);
    end
    return e;
  endfunction

  // H = 0.5*I on the diagonal real words (0, 10, 20, 30), Y from the table.
  function automatic logic [31:0] frameWord(input int k);
    if (k >= 32) return yTab[k - 32];
    if (k == 0 || k == 10 || k == 20 || k == 30) return 32'h0020_0000;
    return 32'h0000_0000;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a write, start pulse or tx byte.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wrQ.size() == 0) begin
        checkOutput("unexpected_wr_en", 64'd1, 64'd0);
      end else begin
        expW = wrQ.pop_front();
        checkOutput("wr_word", {25'd0, wr_sel, wr_row, wr_col, wr_imag, wr_data}, {25'd0, expW});
      end
    end
    if (start_calc === 1'b1) begin
      checkOutput("start_calc_allowed", {63'd0, (startPending > 0) && (wrQ.size() == 0)}, 64'd1);
      if (startPending > 0) startPending--;
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (txQ.size() == 0) begin
        checkOutput("unexpected_tx_byte", {56'd0, tx_data}, 64'hFFFF);
      end else begin
        expTx = txQ.pop_front();
        checkOutput("tx_byte", {56'd0, tx_data}, {56'd0, expTx});
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic sendWord(input int k, input logic [31:0] d);
    wrQ.push_back(expWr(k, d));
    for (int i = 3; i >= 0; i--) applyStimulus(d[i*8 +: 8]);
  endtask

  task automatic sendFrame();
    for (int k = 0; k < 48; k++) sendWord(k, frameWord(k));
  endtask

  task automatic waitStart();
    for (int i = 0; i < 10 && startPending != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("start_calc_seen", 64'(startPending), 64'd0);
  endtask

  task automatic waitIdle(input int limit);
    for (int i = 0; i < limit && busy !== 1'b0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("back_to_idle", {63'd0, busy}, 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},       {63'd0, busy},       64'd0);
    checkOutput({tag, "_wr_en"},      {63'd0, wr_en},      64'd0);
    checkOutput({tag, "_start_calc"}, {63'd0, start_calc}, 64'd0);
    checkOutput({tag, "_tx_valid"},   {63'd0, tx_valid},   64'd0);
    checkOutput({tag, "_frame_err"},  {63'd0, frame_err},  64'd0);
    checkOutput({tag, "_wr_data"},    {32'd0, wr_data},    64'd0);
    checkOutput({tag, "_tx_data"},    {56'd0, tx_data},    64'd0);
  endtask

  initial begin
    int n;
    #3;
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // calc_valid outside WAIT is ignored
    calc_valid  = 1'b1;
    calc_result = 12'h123;
    @(posedge clk);
    #1;
    calc_valid = 1'b0;
    checkOutput("calc_valid_idle_busy", {63'd0, busy}, 64'd0);
    checkOutput("calc_valid_idle_tx",   {63'd0, tx_valid}, 64'd0);

    // only the sync byte starts a frame
    applyStimulus(8'h00);
    checkOutput("ignore_00", {63'd0, busy}, 64'd0);
    applyStimulus(8'h11);
    checkOutput("ignore_11", {63'd0, busy}, 64'd0);
    applyStimulus(8'hA5);
    checkOutput("sync_starts_load", {63'd0, busy}, 64'd1);

    // full frame, then back-pressured result return
    startPending++;
    sendFrame();
    waitStart();
    checkOutput("wait_busy", {63'd0, busy}, 64'd1);
    applyStimulus(8'hA5);
    applyStimulus(8'h3C);
    checkOutput("rx_ignored_in_wait", {63'd0, tx_valid}, 64'd0);
    tx_ready = 1'b0;
    txQ.push_back(8'h0C);
    txQ.push_back(8'hCC);
    calc_valid  = 1'b1;
    calc_result = 12'hCCC;
    @(posedge clk);
    #1;
    calc_valid  = 1'b0;
    calc_result = 12'h000;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_tx_valid", {63'd0, tx_valid}, 64'd1);
      checkOutput("hold_tx_data",  {56'd0, tx_data},  64'h0C);
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b1;
    waitIdle(20);
    checkOutput("tx_queue_drained", 64'(txQ.size()), 64'd0);
    tx_ready = 1'b0;

    // timeout after 50 bytes, with 0xA5 used as ordinary data
    applyStimulus(8'hA5);
    for (int k = 0; k < 12; k++) sendWord(k, (k == 2) ? 32'hA5A5_A5A5 : frameWord(k));
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    n = 0;
    while (frame_err !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("timeout_frame_err", {63'd0, frame_err}, 64'd1);
    checkOutput("timeout_idle",      {63'd0, busy},      64'd0);
    checkOutput("timeout_writes",    64'(wrQ.size()),    64'd0);
    applyStimulus(8'hA5);
    checkOutput("sync_clears_err", {63'd0, frame_err}, 64'd0);
    checkOutput("sync_after_err",  {63'd0, busy},      64'd1);

    // asynchronous reset after 100 bytes
    for (int k = 0; k < 25; k++) sendWord(k, frameWord(k));
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkResetOutputs("midreset");
    checkOutput("midreset_writes", 64'(wrQ.size()), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(8'h00);
    checkOutput("needs_fresh_sync", {63'd0, busy}, 64'd0);

    // full frame after reset, result returned without back-pressure
    applyStimulus(8'hA5);
    startPending++;
    sendFrame();
    waitStart();
    tx_ready = 1'b1;
    txQ.push_back(8'h0C);
    txQ.push_back(8'hCC);
    calc_valid  = 1'b1;
    calc_result = 12'hCCC;
    @(posedge clk);
    #1;
    calc_valid = 1'b0;
    waitIdle(20);
    checkOutput("final_tx_valid",  {63'd0, tx_valid}, 64'd0);
    checkOutput("final_tx_queue",  64'(txQ.size()),   64'd0);
    checkOutput("final_wr_queue",  64'(wrQ.size()),   64'd0);
    checkOutput("final_start",     64'(startPending), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/soml_load_sequencer.md
SOML_LOAD_SEQUENCER -- requirements
Module: soml_load_sequencer

Interface
REQ-001 Parameters: N, default 32, sample word width (Q22 fixed point); TIMEOUT_CYC, default 1000000, maximum idle cycles allowed between bytes inside a frame.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low. clk and rst are the port names.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 rx_data  in  8  received byte from the UART receiver.
REQ-006 rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle.
REQ-007 wr_en  out  1  memory write strobe toward the H/Y stores.
REQ-008 wr_sel  out  2  target store: 0 = H, 1 = Y column 1, 2 = Y column 2.
REQ-009 wr_row, wr_col  out  2 each  element index; wr_col is 0 for Y.
REQ-010 wr_imag  out  1  0 selects the real store, 1 selects the imaginary store.
REQ-011 wr_data  out  N  assembled word.
REQ-012 start_calc  out  1  one-cycle pulse that starts the decoder.
REQ-013 calc_valid  in  1  decoder output_valid level or pulse.
REQ-014 calc_result  in  12  decoder signal_out_12bit.
REQ-015 tx_data  out  8; tx_valid  out  1; tx_ready  in  1  byte handshake toward the UART transmitter.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 frame_err  out  1  sticky flag; set on timeout, cleared by the next accepted sync byte.

Function
REQ-018 States: IDLE, LOAD, START, WAIT, TX_HI, TX_LO.
REQ-019 IDLE: an rx_valid strobe with rx_data = 0xA5 moves the block to LOAD and clears the byte and word counters. Any other byte is ignored.
REQ-020 LOAD: bytes arrive MSB first. Every 4 bytes form one N-bit word. A frame is 48 words (192 bytes).
REQ-021 When the 4th byte of a word arrives, wr_en is high for exactly the next cycle, with all address fields and wr_data stable during that cycle.
REQ-022 Word k < 32 maps to H: row = k/8, col = (k/2)%4, imag = k%2.
REQ-023 Word k from 32 to 47: let j = k-32. Then wr_sel = 1 + j/8, row = (j/2)%4, imag = j%2.
REQ-024 After the write of word 47, the next state is START. START asserts start_calc for exactly 1 cycle, then the block moves to WAIT.
REQ-025 rx_valid in START, WAIT, TX_HI or TX_LO is ignored; it has no effect on state or counters.
REQ-026 WAIT: calc_valid high latches calc_result and moves the block to TX_HI. A calc_valid in any other state is ignored.
REQ-027 TX_HI: tx_data = {4'h0, result[11:8]} and tx_valid = 1. The byte is transferred in the cycle where tx_valid and tx_ready are both high, and the block moves to TX_LO.
REQ-028 TX_LO: tx_data = result[7:0]. On the transfer the block moves to IDLE.
REQ-029 tx_valid and tx_data hold stable until tx_ready; tx_valid is never dropped early.
REQ-030 Timeout in LOAD: an idle counter resets on each rx_valid. Reaching TIMEOUT_CYC sets frame_err, returns the block to IDLE, and issues no start_calc. Words already written are not rolled back.
REQ-031 No timeout applies in WAIT or in the TX states.
REQ-032 A byte value of 0xA5 inside LOAD is treated as data, not as a resync.

Reset
REQ-033 While rst = 0, regardless of clk:
- state = IDLE;
- all counters = 0;
- wr_en, start_calc, tx_valid, busy, frame_err = 0;
- wr_data, tx_data and the latched result = 0.
REQ-034 Reset asserted in the middle of a frame aborts it. The first byte after release needs a fresh 0xA5.

Verification
REQ-035 Send 0xA5 followed by 192 bytes encoding H = 0.5*I (0x00200000 on the diagonal real words, 0 elsewhere) and Y as used in the decoder test. Required:
- exactly 48 wr_en pulses with the mapping of REQ-022/023, e.g. word 10 -> sel 0, row 1, col 1, real, data 0x00200000;
- then one start_calc pulse.
REQ-036 In WAIT, drive calc_valid with calc_result = 0xCCC while tx_ready = 1. Required: tx bytes 0x0C then 0xCC, then IDLE with busy = 0.
REQ-037 Hold tx_ready = 0 for 5 cycles in TX_HI. Required: tx_valid = 1 and tx_data = 0x0C held stable throughout; no byte is lost.
REQ-038 With TIMEOUT_CYC = 100, stop the byte stream after 50 bytes. Required:
- frame_err = 1 within 100 cycles;
- state IDLE and no start_calc;
- a following 0xA5 clears frame_err.
REQ-039 Stream 0x00 0x11 then 0xA5. Required: only the 0xA5 starts LOAD.
REQ-040 Assert rst after 100 bytes. Required: all outputs equal the reset values immediately, without waiting for a clock edge; the next full frame loads correctly.
